// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, filled through a byte-serial valid/ready load port.
// While an image is being loaded (and for RST_HOLD cycles after) the core is held in reset.
module inst_rom_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter bit          BOOT_ON_RST = 1'b1,
    parameter int unsigned RST_HOLD    = 4,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              ld_err_o,
    output logic [ADDR_W:0]   ld_words_o,
    output logic              cpu_rst_o
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_e;
    localparam state_e RST_STATE = BOOT_ON_RST ? LOAD : RUN;

    state_e             state_q, state_d;
    logic [23:0]        shreg_q, shreg_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]    wptr_q, wptr_d;
    logic               err_q, err_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic [31:0]        mem [DEPTH];
    logic               accept, word_due, full, wr_en;
    logic [31:0]        wdata;

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            wptr_q     <= '0;
            err_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            wptr_q     <= wptr_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (ld_start_i) state_d = LOAD;
            LOAD:    if (accept && ld_last_i) state_d = DONE;
            DONE:    if (hold_q == '0) state_d = RUN;
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        cpu_rst_o  = 1'b0;
        ld_ready_o = 1'b0;
        unique case (state_q)
            RUN:     ;
            LOAD:    begin cpu_rst_o = 1'b1; ld_ready_o = 1'b1; end
            DONE:    cpu_rst_o = 1'b1;
            default: ;
        endcase
    end

    assign accept   = (state_q == LOAD) && ld_valid_i;
    assign word_due = accept && ((byte_cnt_q == 2'd3) || ld_last_i);
    assign full     = (wptr_q == (ADDR_W + 1)'(DEPTH));
    assign wr_en    = word_due && !full;

    // A last byte arriving early leaves the unfilled low bytes as zero.
    always_comb begin
        unique case (byte_cnt_q)
            2'd0:    wdata = {ld_byte_i, 24'h0};
            2'd1:    wdata = {shreg_q[7:0], ld_byte_i, 16'h0};
            2'd2:    wdata = {shreg_q[15:0], ld_byte_i, 8'h0};
            default: wdata = {shreg_q, ld_byte_i};
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        wptr_d     = wptr_q;
        err_d      = err_q;
        hold_d     = hold_q;
        if (state_q == RUN && ld_start_i) begin
            byte_cnt_d = '0;
            wptr_d     = '0;
            err_d      = 1'b0;
        end
        if (accept) begin
            shreg_d    = {shreg_q[15:0], ld_byte_i};
            byte_cnt_d = ld_last_i ? 2'd0 : byte_cnt_q + 2'd1;
            if (word_due) begin
                if (full) err_d = 1'b1;
                else      wptr_d = wptr_q + 1'b1;
            end
            if (ld_last_i) hold_d = HOLD_W'(RST_HOLD - 1);
        end
        if (state_q == DONE && hold_q != '0) hold_d = hold_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[ADDR_W-1:0]] <= wdata;
    end

    assign inst_o     = (ce_i && state_q == RUN) ? mem[addr_i[ADDR_W+1:2]] : '0;
    assign ld_err_o   = err_q;
    // The write pointer never passes DEPTH, so it doubles as the saturating word count.
    assign ld_words_o = wptr_q;

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

endmodule
